// File: rtl/image_frame_loader_pkg.sv
// Shared definitions for the framed image loader: FSM states, error codes and
// default framing bytes.
package image_frame_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr2,
    StPayload,
    StCksum,
    StTrl1,
    StTrl2
  } state_e;

  localparam logic [1:0] ERR_CKSUM   = 2'd0;
  localparam logic [1:0] ERR_TRAILER = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEF_HDR1 = 8'hBB;
  localparam logic [7:0] DEF_HDR2 = 8'h66;
  localparam logic [7:0] DEF_TRL1 = 8'h66;
  localparam logic [7:0] DEF_TRL2 = 8'hBB;

  localparam int unsigned DEF_IMG_SIZE = 784;

endpackage

// File: rtl/image_frame_loader_if.sv
// Byte-stream input, buffer write bus and status signals of the frame loader.
// The master side is the loader itself; the slave side is its environment.
interface image_frame_loader_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BANK_W  = 1,
  parameter int unsigned N_BANKS = 2
);
  logic               enable;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               bank_release;
  logic [BANK_W-1:0]  release_id;

  logic               wr_en;
  logic [BANK_W-1:0]  wr_bank;
  logic [ADDR_W-1:0]  wr_addr;
  logic [7:0]         wr_data;
  logic               image_loaded;
  logic [BANK_W-1:0]  loaded_bank;
  logic               frame_error;
  logic [1:0]         err_code;
  logic               busy;
  logic [N_BANKS-1:0] bank_full;

  modport master (
    input  enable, rx_data, rx_valid, bank_release, release_id,
    output wr_en, wr_bank, wr_addr, wr_data, image_loaded, loaded_bank,
           frame_error, err_code, busy, bank_full
  );

  modport slave (
    output enable, rx_data, rx_valid, bank_release, release_id,
    input  wr_en, wr_bank, wr_addr, wr_data, image_loaded, loaded_bank,
           frame_error, err_code, busy, bank_full
  );

endinterface

// File: rtl/image_frame_loader_bank_allocator.sv
// Tracks which image banks are full (holding a finished frame) or claimed
// (currently being filled) and offers the lowest-index free bank.
module image_frame_loader_bank_allocator #(
  parameter int unsigned N_BANKS = 2,
  parameter int unsigned BANK_W  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               claim,
  input  logic               commit,
  input  logic               fail,
  input  logic [BANK_W-1:0]  active,
  input  logic               release_req,
  input  logic [BANK_W-1:0]  release_id,
  output logic [BANK_W-1:0]  free_idx,
  output logic               any_free,
  output logic [N_BANKS-1:0] bank_full
);

  logic [N_BANKS-1:0] full_q, full_d;
  logic [N_BANKS-1:0] claimed_q, claimed_d;
  logic [N_BANKS-1:0] free_mask;

  // Lowest free bank; computed from registered state so a same-cycle release
  // is not yet visible to a claim.
  always_comb begin
    free_mask = ~(full_q | claimed_q);
    free_idx  = '0;
    any_free  = 1'b0;
    for (int i = N_BANKS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_idx = BANK_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // Next-state of full/claimed flags. Only a full bank can be released, so
  // releasing a free or in-fill bank has no effect.
  always_comb begin
    full_d    = full_q;
    claimed_d = claimed_q;
    for (int i = 0; i < N_BANKS; i++) begin
      if (release_req && (release_id == BANK_W'(i)) && full_q[i]) begin
        full_d[i] = 1'b0;
      end
      if (claim && (free_idx == BANK_W'(i))) begin
        claimed_d[i] = 1'b1;
      end
      if ((commit || fail) && (active == BANK_W'(i))) begin
        claimed_d[i] = 1'b0;
      end
      if (commit && (active == BANK_W'(i))) begin
        full_d[i] = 1'b1;
      end
    end
  end

  // Bank flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      claimed_q <= '0;
    end else begin
      full_q    <= full_d;
      claimed_q <= claimed_d;
    end
  end

  assign bank_full = full_q;

endmodule

// File: rtl/image_frame_loader.sv
// Parses framed images (header, fixed payload, XOR checksum, trailer) from a
// byte stream and writes the payload into one of several image banks.
module image_frame_loader
  import image_frame_loader_pkg::*;
#(
  parameter int unsigned IMG_SIZE    = DEF_IMG_SIZE,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned BANK_W      = 1,
  parameter logic [7:0]  HDR1        = DEF_HDR1,
  parameter logic [7:0]  HDR2        = DEF_HDR2,
  parameter logic [7:0]  TRL1        = DEF_TRL1,
  parameter logic [7:0]  TRL2        = DEF_TRL2,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input logic clk,
  input logic rst,
  image_frame_loader_if.master bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [BANK_W-1:0] cur_bank_q, cur_bank_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              wr_en_q, wr_en_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              loaded_q, loaded_d;
  logic [BANK_W-1:0] loaded_bank_q, loaded_bank_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              claim, commit, fail;
  logic [BANK_W-1:0] free_idx;
  logic              any_free;
  logic              has_bank;
  logic              tmo_hit;

  image_frame_loader_bank_allocator #(
    .N_BANKS(N_BANKS),
    .BANK_W (BANK_W)
  ) u_alloc (
    .clk        (clk),
    .rst        (rst),
    .claim      (claim),
    .commit     (commit),
    .fail       (fail),
    .active     (cur_bank_q),
    .release_req(bus.bank_release),
    .release_id (bus.release_id),
    .free_idx   (free_idx),
    .any_free   (any_free),
    .bank_full  (bus.bank_full)
  );

  // Frame parser: next state, bank bookkeeping and registered outputs.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    csum_d        = csum_q;
    cur_bank_d    = cur_bank_q;
    wr_en_d       = 1'b0;
    wr_bank_d     = wr_bank_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    loaded_d      = 1'b0;
    loaded_bank_d = loaded_bank_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    claim         = 1'b0;
    commit        = 1'b0;
    fail          = 1'b0;

    has_bank = (state_q == StPayload) || (state_q == StCksum) ||
               (state_q == StTrl1) || (state_q == StTrl2);
    tmo_hit  = (state_q != StIdle) && !bus.rx_valid &&
               (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Idle clocks since the last byte; only meaningful inside a frame.
    if ((state_q == StIdle) || bus.rx_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (!bus.enable) begin
      // Silent abort: free any claimed bank, no error pulse.
      state_d = StIdle;
      fail    = has_bank;
    end else if (tmo_hit) begin
      state_d    = StIdle;
      fail       = has_bank;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else if (bus.rx_valid) begin
      case (state_q)
        StIdle: begin
          if (bus.rx_data == HDR1) state_d = StHdr2;
        end
        StHdr2: begin
          if (bus.rx_data == HDR2) begin
            if (any_free) begin
              state_d    = StPayload;
              claim      = 1'b1;
              cur_bank_d = free_idx;
              byte_cnt_d = '0;
              csum_d     = '0;
            end else begin
              state_d    = StIdle;
              err_d      = 1'b1;
              err_code_d = ERR_OVERRUN;
            end
          end else if (bus.rx_data != HDR1) begin
            state_d = StIdle;
          end
        end
        StPayload: begin
          // Payload bytes are pure data, even when they match a marker.
          wr_en_d    = 1'b1;
          wr_bank_d  = cur_bank_q;
          wr_addr_d  = byte_cnt_q;
          wr_data_d  = bus.rx_data;
          csum_d     = csum_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + ADDR_W'(1);
          if (byte_cnt_q == ADDR_W'(IMG_SIZE - 1)) state_d = StCksum;
        end
        StCksum: begin
          if (bus.rx_data == csum_q) begin
            state_d = StTrl1;
          end else begin
            state_d    = StIdle;
            fail       = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_CKSUM;
          end
        end
        StTrl1: begin
          if (bus.rx_data == TRL1) begin
            state_d = StTrl2;
          end else begin
            state_d    = StIdle;
            fail       = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_TRAILER;
          end
        end
        StTrl2: begin
          state_d = StIdle;
          if (bus.rx_data == TRL2) begin
            commit        = 1'b1;
            loaded_d      = 1'b1;
            loaded_bank_d = cur_bank_q;
          end else begin
            fail       = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_TRAILER;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      byte_cnt_q    <= '0;
      csum_q        <= '0;
      cur_bank_q    <= '0;
      tmo_q         <= '0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      loaded_q      <= 1'b0;
      loaded_bank_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      csum_q        <= csum_d;
      cur_bank_q    <= cur_bank_d;
      tmo_q         <= tmo_d;
      wr_en_q       <= wr_en_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      loaded_q      <= loaded_d;
      loaded_bank_q <= loaded_bank_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_bank      = wr_bank_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.image_loaded = loaded_q;
  assign bus.loaded_bank  = loaded_bank_q;
  assign bus.frame_error  = err_q;
  assign bus.err_code     = err_code_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_image_frame_loader.sv
// Byte-level bench for image_frame_loader: random pixel frames, checksum and
// trailer errors, overrun, timeout, enable drop and mid-frame reset, checked
// against a frame-level model of banks, writes and events.
module tb_image_frame_loader;

  localparam int IMG = 784;
  localparam int NB  = 2;
  localparam int BW  = 1;
  localparam int AW  = 10;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  image_frame_loader_if #(.ADDR_W(AW), .BANK_W(BW), .N_BANKS(NB)) bus ();

  image_frame_loader #(
    .IMG_SIZE   (IMG),
    .ADDR_W     (AW),
    .N_BANKS    (NB),
    .BANK_W     (BW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int excl_viol = 0;
  int last_rx_cyc = 0;
  int w_bank[$], w_addr[$], w_data[$];
  int ev_kind[$], ev_val[$], ev_cyc[$];
  int model_full[NB];
  int pix[IMG];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes and event pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      w_bank.push_back(int'(bus.wr_bank));
      w_addr.push_back(int'(bus.wr_addr));
      w_data.push_back(int'(bus.wr_data));
    end
    if (bus.image_loaded) begin
      ev_kind.push_back(1); ev_val.push_back(int'(bus.loaded_bank)); ev_cyc.push_back(cyc);
    end
    if (bus.frame_error) begin
      ev_kind.push_back(2); ev_val.push_back(int'(bus.err_code)); ev_cyc.push_back(cyc);
    end
    if (bus.image_loaded && bus.frame_error) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NB; i++) if (model_full[i] == 0) return i;
    return -1;
  endfunction

  function automatic logic [31:0] full_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NB; i++) v[i] = (model_full[i] != 0);
    return v;
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.image_loaded,
                bus.loaded_bank, bus.frame_error, bus.err_code, bus.busy, bus.bank_full});
  endfunction

  function automatic int rgap();
    return int'($urandom_range(0, 2));
  endfunction

  task automatic clear_logs();
    w_bank.delete(); w_addr.delete(); w_data.delete();
    ev_kind.delete(); ev_val.delete(); ev_cyc.delete();
  endtask

  // Called at a negedge; the byte is sampled on the following posedge.
  task automatic send_byte(input int b, input int gap);
    bus.rx_data  = 8'(b);
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    last_rx_cyc  = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic fill_pix(input int pat);
    for (int i = 0; i < IMG; i++) pix[i] = (pat == 0) ? (i % 256) : int'($urandom_range(0, 255));
    if (pat == 1) begin
      pix[100] = 8'h66; pix[101] = 8'hBB;
      pix[400] = 8'hBB; pix[401] = 8'h66;
      pix[IMG-1] = 8'hBB;
    end
  endtask

  function automatic int pix_csum();
    int c = 0;
    for (int i = 0; i < IMG; i++) c = c ^ pix[i];
    return c;
  endfunction

  task automatic check_writes(input string tag, input int n, input int bank);
    int first_bad = -1;
    check({tag, "_wr_cnt"}, w_data.size(), n);
    for (int i = 0; i < w_data.size() && i < n; i++) begin
      if (first_bad < 0 && (w_bank[i] != bank || w_addr[i] != i || w_data[i] != pix[i]))
        first_bad = i;
    end
    check({tag, "_wr_first_bad"}, first_bad, -1);
  endtask

  task automatic check_event(input string tag, input int kind, input int val);
    check({tag, "_ev_cnt"}, ev_kind.size(), 1);
    if (ev_kind.size() > 0) begin
      check({tag, "_ev_kind"}, ev_kind[0], kind);
      check({tag, "_ev_val"}, ev_val[0], val);
    end
  endtask

  task automatic send_header();
    send_byte(8'hBB, rgap());
    send_byte(8'h66, rgap());
  endtask

  // mode: 0 good frame, 1 checksum error, 2 bad second trailer byte
  task automatic run_frame(input string tag, input int pat, input int mode);
    int b;
    int cs;
    clear_logs();
    fill_pix(pat);
    b = lowest_free();
    send_header();
    if (b < 0) begin
      repeat (3) @(negedge clk);
      check({tag, "_wr_cnt"}, w_data.size(), 0);
      check_event(tag, 2, 3);
    end else begin
      for (int i = 0; i < IMG; i++) send_byte(pix[i], rgap());
      cs = pix_csum();
      if (mode == 1) begin
        send_byte(cs ^ 1, 0);
      end else begin
        send_byte(cs, rgap());
        send_byte(8'h66, rgap());
        send_byte((mode == 2) ? 8'h00 : 8'hBB, 0);
      end
      repeat (3) @(negedge clk);
      check_writes(tag, IMG, b);
      if (mode == 0) begin
        check_event(tag, 1, b);
        model_full[b] = 1;
      end else begin
        check_event(tag, 2, (mode == 1) ? 0 : 1);
      end
    end
    check({tag, "_bank_full"}, bus.bank_full, full_vec());
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic release_bank(input int id);
    bus.bank_release = 1'b1;
    bus.release_id   = BW'(id);
    @(negedge clk);
    bus.bank_release = 1'b0;
    model_full[id]   = 0;
    @(negedge clk);
  endtask

  initial begin
    int b;
    for (int i = 0; i < NB; i++) model_full[i] = 0;
    bus.enable = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    bus.bank_release = 1'b0; bus.release_id = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", out_vec(), 0);
    rst = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);

    run_frame("good_ramp", 0, 0);
    check("first_full_01", bus.bank_full, 2'b01);
    release_bank(0);
    check("released_00", bus.bank_full, 2'b00);
    run_frame("bad_csum", 2, 1);
    run_frame("markers", 1, 0);
    run_frame("good_b1", 2, 0);
    run_frame("overrun", 2, 0);
    release_bank(0);
    run_frame("after_rel", 2, 0);
    release_bank(0);
    release_bank(1);

    // Timeout after 10 payload bytes.
    clear_logs();
    fill_pix(2);
    b = lowest_free();
    send_header();
    for (int i = 0; i < 10; i++) send_byte(pix[i], (i == 9) ? 0 : rgap());
    for (int t = 0; t < 200 && ev_kind.size() == 0; t++) @(negedge clk);
    check_event("timeout", 2, 2);
    if (ev_kind.size() > 0) check("timeout_latency", ev_cyc[0] - last_rx_cyc, TMO);
    check_writes("timeout", 10, b);
    check("timeout_busy", bus.busy, 0);
    check("timeout_bank_full", bus.bank_full, full_vec());

    // Enable dropped mid-payload: silent abort.
    clear_logs();
    fill_pix(2);
    b = lowest_free();
    send_header();
    for (int i = 0; i < 20; i++) send_byte(pix[i], (i == 19) ? 0 : rgap());
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check("en_drop_ev_cnt", ev_kind.size(), 0);
    check("en_drop_busy", bus.busy, 0);
    check_writes("en_drop", 20, b);
    check("en_drop_bank_full", bus.bank_full, full_vec());
    bus.enable = 1'b1;
    @(negedge clk);
    run_frame("post_en", 0, 0);

    run_frame("bad_trl", 2, 2);

    // Reset while a payload byte is being accepted.
    clear_logs();
    fill_pix(2);
    send_header();
    for (int i = 0; i < 5; i++) send_byte(pix[i], rgap());
    bus.rx_data = 8'h5A; bus.rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", out_vec(), 0);
    rst = 1'b0; bus.rx_valid = 1'b0;
    for (int i = 0; i < NB; i++) model_full[i] = 0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) release_bank(int'($urandom_range(0, NB - 1)));
      run_frame($sformatf("rnd%0d", k), 2, int'($urandom_range(0, 2)));
    end

    check("pulse_exclusive", excl_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_frame_loader.md
Name: image_frame_loader

Overview:
- Parametrised successor to the single-buffer image loader.
- Consumes a byte stream from an external uart_rx and parses framed images: header, fixed-length payload, XOR checksum, trailer.
- Writes payload into one of N_BANKS image buffers, so inference on bank k overlaps reception into bank k+1.
- Reports completed frames, and reports protocol errors with a code instead of silently dropping them.

Parameters:
- IMG_SIZE, 784, payload bytes per frame (>=1).
- ADDR_W, 10, pixel address width; must satisfy 2**ADDR_W >= IMG_SIZE.
- N_BANKS, 2, number of image buffers (1..4).
- BANK_W, 1, bank index width; must satisfy 2**BANK_W >= N_BANKS.
- HDR1, 8'hBB, first header byte.
- HDR2, 8'h66, second header byte.
- TRL1, 8'h66, first trailer byte.
- TRL2, 8'hBB, second trailer byte.
- TIMEOUT_CYC, 1_000_000, idle clocks inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  weights_loaded gate; frames are accepted only while high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- bank_release  in  1  consumer finished with bank release_id
- release_id  in  BANK_W  bank being released
- wr_en  out  1  buffer write strobe
- wr_bank  out  BANK_W  target bank
- wr_addr  out  ADDR_W  pixel address
- wr_data  out  8  pixel value
- image_loaded  out  1  one-cycle pulse: frame complete and valid
- loaded_bank  out  BANK_W  bank of the completed frame, valid with image_loaded
- frame_error  out  1  one-cycle pulse: frame aborted
- err_code  out  2  0=checksum, 1=bad trailer, 2=timeout, 3=overrun; valid with frame_error
- busy  out  1  high in every state except S_IDLE
- bank_full  out  N_BANKS  per-bank full flags

Behaviour:
- Reset: all outputs 0, state S_IDLE, all banks free, counters 0.
- States and transitions:
  - S_IDLE: HDR1 -> S_HDR2.
  - S_HDR2:
    - HDR2 with a free bank -> S_PAYLOAD; claim the lowest-index free bank; byte_cnt=0; csum=0.
    - HDR2 with no free bank -> frame_error, err=3, back to S_IDLE.
    - HDR1 -> stay in S_HDR2.
    - Any other byte -> S_IDLE.
  - S_PAYLOAD: each rx_valid writes the byte at addr=byte_cnt and sets csum^=byte. When byte_cnt==IMG_SIZE-1 -> S_CKSUM.
  - S_CKSUM: byte==csum -> S_TRL1; otherwise error code 0.
  - S_TRL1: TRL1 -> S_TRL2; otherwise error code 1.
  - S_TRL2: TRL2 -> success; otherwise error code 1.
- Framing is count-based. Payload bytes equal to any marker value are stored as data, never interpreted.
- Write latency: wr_en/wr_bank/wr_addr/wr_data are registered and asserted the cycle after the accepting rx_valid. Exactly IMG_SIZE writes occur per accepted frame.
- Success: the cycle after the TRL2 byte:
  - image_loaded=1 and loaded_bank=claimed bank;
  - that bank's bank_full bit is set;
  - state returns to S_IDLE.
- Error: the cycle after the offending byte or timeout:
  - frame_error=1 with err_code;
  - the claimed bank is returned to free, and its partial contents are don't-care;
  - state returns to S_IDLE.
- Timeout: a counter resets on every rx_valid and while in S_IDLE. Reaching TIMEOUT_CYC in any other state aborts with code 2.
- bank_release: clears bank_full[release_id], visible from the next cycle.
  - Releasing a free bank, or the bank currently being filled, is ignored.
  - A release and a claim in the same cycle: the claim sees the pre-release state.
- enable low: forces S_IDLE next cycle. A frame in flight is aborted silently: no error pulse, bank freed. bank_full is retained.
- image_loaded and frame_error are never high in the same cycle.
- N_BANKS=1 degenerates to single-buffer behaviour, with overrun reported until that bank is released.

Decomposition:
- Shared package (loader_pkg):
  - state encoding;
  - err_code constants: ERR_CKSUM, ERR_TRAILER, ERR_TIMEOUT, ERR_OVERRUN;
  - default marker bytes;
  - IMG_SIZE default.
- One natural sub-module, bank_allocator:
  - inputs: free mask, claim, release, fail;
  - outputs: lowest-free index, any_free, bank_full.
- uart_rx stays external, so the block is testable at byte level.

Test Plan:
- Valid frame, IMG_SIZE=784, pixels i%256, correct csum, trailer 66 BB:
  - 784 writes to bank 0, addr 0..783;
  - image_loaded pulse with loaded_bank=0;
  - bank_full=01.
- Payload containing 66 BB at bytes 100-101, and BB 66 inside:
  - all stored as data;
  - frame completes normally only after byte 784 + csum + trailer.
- Checksum error: correct frame except csum XOR 0x01 -> frame_error with err_code=0; bank 0 stays free; the next frame goes to bank 0.
- Overrun, N_BANKS=2:
  - two good frames with no release -> banks 0 and 1 full;
  - third header -> err_code=3 with no writes;
  - bank_release with id 0, then a frame -> loaded_bank=0.
- Timeout, TIMEOUT_CYC=50: stop after 10 payload bytes -> frame_error with err_code=2 at exactly 50 cycles after the last rx_valid; busy drops.
- Disruptions:
  - enable deasserted mid-payload -> no error pulse, bank freed, S_IDLE;
  - bad trailer (66 00) -> err_code=1;
  - rst mid-frame -> all outputs 0 next cycle.
